// File: rtl/regfile_write_buffer_pkg.sv
// rtl/regfile_write_buffer_pkg.sv - datapath definitions shared by the write-back buffer
package regfile_write_buffer_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] wreg;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Control-word encodings, kept here so the decoder can reuse them
    localparam logic REGDST_RT    = 1'b0;
    localparam logic REGDST_RD    = 1'b1;
    localparam logic MEMTOREG_ALU = 1'b0;
    localparam logic MEMTOREG_MEM = 1'b1;

endpackage

// File: rtl/regfile_write_buffer_fifo.sv
// rtl/regfile_write_buffer_fifo.sv - in-order result queue with age-ordered view for forwarding
module wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           flush,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              push_reg,
    input  logic [DATA_W-1:0]              push_data,
    output logic [CNT_W-1:0]               count,
    output logic [DEPTH-1:0]               age_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]   age_reg,
    output logic [DEPTH-1:0][DATA_W-1:0]   age_data
);

    logic [ADDR_W-1:0] mem_reg  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;
    logic              clear;

    assign clear   = !resetn || flush;
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (!clear && do_push) begin
            mem_reg[wr_ptr]  <= push_reg;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // Index 0 is the head (oldest); higher indices are progressively younger
    always_comb begin
        age_valid = '0;
        age_reg   = '0;
        age_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            age_valid[k] = CNT_W'(k) < count;
            age_reg[k]   = mem_reg[rd_ptr + PTR_W'(k)];
            age_data[k]  = mem_data[rd_ptr + PTR_W'(k)];
        end
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// rtl/regfile_write_buffer.sv - write-back result queue draining into the register file with forwarding
module regfile_write_buffer #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DROP_R0 = 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              InValid,
    output logic              InReady,
    input  logic              RegDst,
    input  logic              MemtoReg,
    input  logic [ADDR_W-1:0] Rt,
    input  logic [ADDR_W-1:0] Rd,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] MemData,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    input  logic              WriteAck,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic              Fwd1Valid,
    output logic              Fwd2Valid,
    output logic [DATA_W-1:0] Fwd1Data,
    output logic [DATA_W-1:0] Fwd2Data,
    output logic [CNT_W-1:0]  Count
);

    import regfile_write_buffer_pkg::*;

    logic [ADDR_W-1:0]             dest;
    logic [DATA_W-1:0]             wdata;
    logic                          accept;
    logic                          push;
    logic [DEPTH-1:0]              age_valid;
    logic [DEPTH-1:0][ADDR_W-1:0]  age_reg;
    logic [DEPTH-1:0][DATA_W-1:0]  age_data;

    assign dest    = (RegDst == REGDST_RD) ? Rd : Rt;
    assign wdata   = (MemtoReg == MEMTOREG_MEM) ? MemData : ALUOut;
    assign InReady = RESET && !Flush && (Count < CNT_W'(DEPTH));
    assign accept  = InValid && InReady;
    // A write to the hardwired zero register completes the handshake but is not queued
    assign push    = accept && !((DROP_R0 != 0) && (dest == ADDR_W'(ZERO_REG)));

    wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (CLK),
        .resetn    (RESET),
        .flush     (Flush),
        .push      (push),
        .pop       (WriteAck),
        .push_reg  (dest),
        .push_data (wdata),
        .count     (Count),
        .age_valid (age_valid),
        .age_reg   (age_reg),
        .age_data  (age_data)
    );

    assign RegWrite  = (Count != '0);
    assign WriteReg  = RegWrite ? age_reg[0]  : '0;
    assign WriteData = RegWrite ? age_data[0] : '0;

    // Scanning oldest to youngest lets the youngest match win
    always_comb begin
        Fwd1Valid = 1'b0;
        Fwd1Data  = '0;
        Fwd2Valid = 1'b0;
        Fwd2Data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k] && age_reg[k] == ReadReg1 &&
                !((DROP_R0 != 0) && ReadReg1 == ADDR_W'(ZERO_REG))) begin
                Fwd1Valid = 1'b1;
                Fwd1Data  = age_data[k];
            end
            if (age_valid[k] && age_reg[k] == ReadReg2 &&
                !((DROP_R0 != 0) && ReadReg2 == ADDR_W'(ZERO_REG))) begin
                Fwd2Valid = 1'b1;
                Fwd2Data  = age_data[k];
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb/tb_regfile_write_buffer.sv - self-checking bench for regfile_write_buffer against a queue model
module tb_regfile_write_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              CLK = 1'b0;
    logic              RESET, InValid, InReady, RegDst, MemtoReg;
    logic [ADDR_W-1:0] Rt, Rd, WriteReg, ReadReg1, ReadReg2;
    logic [DATA_W-1:0] ALUOut, MemData, WriteData, Fwd1Data, Fwd2Data;
    logic              RegWrite, WriteAck, Flush, Fwd1Valid, Fwd2Valid;
    logic [2:0]        Count;

    always #5 CLK = ~CLK;

    regfile_write_buffer #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_R0(1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .InValid(InValid), .InReady(InReady),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .Rt(Rt), .Rd(Rd),
        .ALUOut(ALUOut), .MemData(MemData), .RegWrite(RegWrite),
        .WriteReg(WriteReg), .WriteData(WriteData), .WriteAck(WriteAck),
        .Flush(Flush), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .Fwd1Valid(Fwd1Valid), .Fwd2Valid(Fwd2Valid),
        .Fwd1Data(Fwd1Data), .Fwd2Data(Fwd2Data), .Count(Count)
    );

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic lookup(input logic [ADDR_W-1:0] rr, output logic v, output logic [31:0] d);
        v = 1'b0;
        d = '0;
        if (rr != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].r == rr) begin
                    v = 1'b1;
                    d = q[i].d;
                    break;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic        v;
        logic [31:0] d;
        check("InReady", InReady, RESET && !Flush && (q.size() < DEPTH));
        check("RegWrite", RegWrite, q.size() != 0);
        if (q.size() != 0) begin
            check("WriteReg", WriteReg, q[0].r);
            check("WriteData", WriteData, q[0].d);
        end else begin
            check("WriteReg", WriteReg, 0);
            check("WriteData", WriteData, 0);
        end
        check("Count", Count, q.size());
        lookup(ReadReg1, v, d);
        check("Fwd1Valid", Fwd1Valid, v);
        check("Fwd1Data", Fwd1Data, d);
        lookup(ReadReg2, v, d);
        check("Fwd2Valid", Fwd2Valid, v);
        check("Fwd2Data", Fwd2Data, d);
    endtask

    task automatic update_model();
        logic              rdy;
        logic [ADDR_W-1:0] dst;
        rdy = RESET && !Flush && (q.size() < DEPTH);
        if (!RESET || Flush) begin
            q.delete();
        end else begin
            if (WriteAck && q.size() != 0) void'(q.pop_front());
            if (InValid && rdy) begin
                dst = RegDst ? Rd : Rt;
                if (dst != 0) q.push_back('{dst, MemtoReg ? MemData : ALUOut});
            end
        end
    endtask

    task automatic cycle();
        @(negedge CLK);
        compare_all();
        @(posedge CLK);
        update_model();
        #1;
    endtask

    task automatic set_rd(input int r, input int d);
        RegDst   = 1'b1;
        MemtoReg = 1'b0;
        Rd       = ADDR_W'(r);
        ALUOut   = DATA_W'(d);
    endtask

    initial begin
        RESET = 0; InValid = 0; RegDst = 0; MemtoReg = 0; Rt = 0; Rd = 0;
        ALUOut = 0; MemData = 0; WriteAck = 0; Flush = 0; ReadReg1 = 0; ReadReg2 = 0;
        @(posedge CLK);
        #1;

        // Reset held with InValid asserted
        InValid = 1;
        set_rd(3, 9);
        cycle();
        check("reset_inready", InReady, 0);
        RESET = 1; InValid = 0;
        check("reset_count", Count, 0);
        check("reset_regwrite", RegWrite, 0);
        cycle();

        // Single R-type
        set_rd(2, 7); InValid = 1; WriteAck = 1;
        cycle();
        InValid = 0;
        check("rtype_wreg", WriteReg, 2);
        check("rtype_wdata", WriteData, 7);
        cycle();
        check("rtype_drained", Count, 0);

        // Fill and drain with a held 5th item
        WriteAck = 0; InValid = 1;
        for (int i = 0; i < 4; i++) begin
            set_rd(8 + i, 'h10 + i);
            cycle();
        end
        check("fill_count", Count, 4);
        check("fill_inready", InReady, 0);
        set_rd(12, 'h14);
        cycle();
        cycle();
        WriteAck = 1;
        cycle();
        check("drain_wreg9", WriteReg, 9);
        check("drain_ready", InReady, 1);
        cycle();
        InValid = 0;
        check("drain_wreg10", WriteReg, 10);
        for (int i = 0; i < 4; i++) cycle();
        check("drain_empty", Count, 0);

        // Youngest-match forwarding
        WriteAck = 0; InValid = 1;
        set_rd(5, 1);
        cycle();
        set_rd(5, 2);
        cycle();
        InValid = 0; ReadReg1 = 5; ReadReg2 = 6;
        #1;
        check("fwd1_valid", Fwd1Valid, 1);
        check("fwd1_data", Fwd1Data, 2);
        check("fwd2_valid", Fwd2Valid, 0);
        check("fwd2_data", Fwd2Data, 0);
        cycle();
        WriteAck = 1;
        cycle();
        cycle();

        // Register 0 drop
        WriteAck = 0; RegDst = 0; Rt = 0; MemtoReg = 1; MemData = 'hFF;
        InValid = 1; ReadReg1 = 0;
        cycle();
        InValid = 0;
        check("r0_count", Count, 0);
        check("r0_regwrite", RegWrite, 0);
        check("r0_fwd", Fwd1Valid, 0);
        cycle();

        // Flush wins over a simultaneous push
        InValid = 1;
        for (int i = 1; i <= 3; i++) begin
            set_rd(i, 'h100 + i);
            cycle();
        end
        ReadReg1 = 2;
        set_rd(4, 'h104); Flush = 1;
        cycle();
        Flush = 0; InValid = 0;
        check("flush_count", Count, 0);
        check("flush_regwrite", RegWrite, 0);
        cycle();

        // Reset in the middle of a drain
        InValid = 1;
        for (int i = 0; i < 2; i++) begin
            set_rd(20 + i, 'h200 + i);
            cycle();
        end
        InValid = 0; WriteAck = 1; RESET = 0;
        cycle();
        RESET = 1;
        check("mreset_count", Count, 0);
        check("mreset_regwrite", RegWrite, 0);
        cycle();
        cycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            InValid  = $urandom_range(0, 3) != 0;
            RegDst   = $urandom_range(0, 1);
            MemtoReg = $urandom_range(0, 1);
            Rt       = ADDR_W'($urandom_range(0, 7));
            Rd       = ADDR_W'($urandom_range(0, 7));
            ALUOut   = $urandom;
            MemData  = $urandom;
            WriteAck = $urandom_range(0, 2) == 0;
            Flush    = $urandom_range(0, 24) == 0;
            RESET    = $urandom_range(0, 39) != 0;
            ReadReg1 = ADDR_W'($urandom_range(0, 7));
            ReadReg2 = ADDR_W'($urandom_range(0, 7));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
- Write-back side of the datapath: accepts completed results from the ALU or memory stage and holds them in a small in-order queue.
- Drains one entry per accepted cycle into the register file write port (RegWrite/WriteReg/WriteData).
- Supplies forwarding data for results that are still queued, so register-file reads see pending writes.
- Sits between MIPSALU/data memory and REGISTERS.

Parameters:
- DEPTH, 4, queue entries; power of 2, at least 2.
- DATA_W, 32, result width.
- ADDR_W, 5, register index width.
- DROP_R0, 1, when 1 register 0 is hardwired: writes to it are discarded and lookups of it never hit.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset: synchronous, active-low (0 = reset).
- InValid  in  1  result available.
- InReady  out  1  buffer can accept.
- RegDst  in  1  1 selects Rd as destination, 0 selects Rt.
- MemtoReg  in  1  1 selects MemData as write data, 0 selects ALUOut.
- Rt  in  ADDR_W  rt field.
- Rd  in  ADDR_W  rd field.
- ALUOut  in  DATA_W  ALU result.
- MemData  in  DATA_W  load data.
- RegWrite  out  1  head entry is valid toward the register file.
- WriteReg  out  ADDR_W  head destination register.
- WriteData  out  DATA_W  head data.
- WriteAck  in  1  register file consumed the head this cycle.
- Flush  in  1  discard all queued entries.
- ReadReg1  in  ADDR_W  forwarding lookup index, port 1.
- ReadReg2  in  ADDR_W  forwarding lookup index, port 2.
- Fwd1Valid, Fwd2Valid  out  1  a queued entry matches the corresponding ReadReg.
- Fwd1Data, Fwd2Data  out  DATA_W  data of the matching entry.
- Count  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (RESET==0 at posedge):
  - Count=0, read/write pointers=0.
  - RegWrite=0, WriteReg=0, WriteData=0, Fwd*Valid=0, Fwd*Data=0.
  - InReady=0 while RESET==0.
  - Storage array is not cleared.
  - Reset mid-drain discards all entries with no further RegWrite.
- Destination and data selection:
  - dest = RegDst ? Rd : Rt.
  - data = MemtoReg ? MemData : ALUOut.
  - Both are sampled at the accept edge.
- Handshake:
  - InReady = RESET && !Flush && (Count < DEPTH), combinational.
  - Accept = InValid && InReady at posedge; there is no full-bypass, so InReady stays 0 when full even if a pop occurs that cycle.
- R0 drop: with DROP_R0=1 and dest==0, the accept completes but nothing is enqueued and Count is unchanged.
- Enqueue: the entry is written at the tail; the tail pointer increments modulo DEPTH.
- Output latency: 1 cycle. An entry accepted at edge N is visible on RegWrite/WriteReg/WriteData after edge N, when it is at the head.
- Output drive: RegWrite = (Count != 0). WriteReg/WriteData show the head entry and are forced to 0 when empty.
- Pop: when RegWrite && WriteAck at posedge, the head pointer increments modulo DEPTH. WriteAck while empty is ignored.
- Occupancy update:
  - Push and pop in the same cycle: Count unchanged, pointers both advance.
  - Push only: +1. Pop only: −1.
- Ordering: strict FIFO; writes reach the register file in accept order.
- Flush (synchronous):
  - Count=0 and pointers=0 at the next edge.
  - Takes priority over push and pop in the same cycle; InReady is already 0 during Flush.
  - Flush with RESET==0 behaves as reset.
- Forwarding (combinational over valid entries only):
  - FwdNValid=1 if any queued entry's reg == ReadRegN.
  - FwdNData = data of the youngest matching entry (nearest the tail); FwdNData=0 when there is no hit.
  - ReadRegN==0 with DROP_R0=1 never hits.
  - The entry at the head still counts as a hit in the cycle it is popped.
  - The entry being accepted in the current cycle is not searched.
- Arithmetic: pointers are clog2(DEPTH) bits and wrap naturally; Count saturates by construction (no push when full, no pop when empty).

Decomposition:
- Shared package (datapath defs), holds:
  - DATA_W, ADDR_W, ZERO_REG=0.
  - wb_entry_t typedef {reg[ADDR_W], data[DATA_W]}.
- Shared with the CONTROL encoding for future reuse: RegDst/MemtoReg selection constants.
- One sub-module, wb_fifo: storage, pointers, Count, Flush.
- Top level keeps the destination/data muxing, R0 drop and the forwarding search.

Test Plan:
- Reset: hold RESET=0 for 2 cycles with InValid=1 → InReady=0; after release Count=0, RegWrite=0, WriteReg=0, no entry enqueued.
- Single R-type: RegDst=1, Rd=2, ALUOut=7, WriteAck=1 → next cycle RegWrite=1, WriteReg=2, WriteData=7; the cycle after, RegWrite=0 and Count=0.
- Fill and drain:
  - WriteAck=0, push regs 8,9,10,11 with data 0x10..0x13 → Count=4, InReady=0; a 5th pushed item is held on the input.
  - Raise WriteAck → WriteReg sequence 8,9,10,11 on consecutive cycles; InReady=1 one cycle after the first pop.
  - The 5th item is accepted and drains last.
- Forwarding: WriteAck=0, push reg 5 data 1 then reg 5 data 2; set ReadReg1=5, ReadReg2=6 → Fwd1Valid=1, Fwd1Data=2, Fwd2Valid=0, Fwd2Data=0.
- R0 drop: RegDst=0, Rt=0, MemtoReg=1, MemData=0xFF, InValid=1 → handshake completes, Count stays 0, RegWrite never asserts; ReadReg1=0 → Fwd1Valid=0.
- Flush and mid-drain reset:
  - With 3 entries queued, assert Flush together with InValid=1 → next cycle Count=0, RegWrite=0, pushed item dropped.
  - Refill 2 entries, drop RESET for one edge while WriteAck=1 → Count=0 and no further writes.
